// File: rtl/in_halt_responder_if.sv
// Handshake bundle between the control unit and the IN halt responder.
//   halt_req  : control unit -> responder, IN decoded (combinational Halt)
//   cpu_stall : responder -> CPU, hold PC and register-file write while high
//   in_valid  : responder -> CPU, one-cycle pulse, in_data must be written now
//   in_data   : responder -> CPU, latched switch value, zero-extended
// master = control unit / CPU side, slave = responder side.
interface in_halt_responder_if #(
  parameter int DATA_W = 32
);
  logic              halt_req;
  logic              cpu_stall;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  modport master (
    output halt_req,
    input  cpu_stall,
    input  in_valid,
    input  in_data
  );

  modport slave (
    input  halt_req,
    output cpu_stall,
    output in_valid,
    output in_data
  );
endinterface

// File: rtl/in_halt_responder.sv
// in_halt_responder
//   Responder side of the IN-instruction halt handshake. While the control unit
//   holds Halt, the CPU is stalled until the user has released Enter, pressed it
//   again cleanly, and the press has been debounced. The switch value is then
//   latched and the stall is dropped for exactly one cycle (in_valid), so the
//   register-file write and the PC advance share that single cycle.
// Ports
//   clock       : system clock, rising edge
//   reset       : synchronous, active-high
//   bus         : slave side of in_halt_responder_if (halt_req in;
//                 cpu_stall, in_valid, in_data out)
//   switches    : raw board switches, sampled only when the press is accepted
//   enter_btn   : raw Enter push-button, active-high, asynchronous
//   waiting_led : high while the responder is waiting on the user
module in_halt_responder #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 16,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic                clock,
  input  logic                reset,
  in_halt_responder_if.slave  bus,
  input  logic [SW_W-1:0]     switches,
  input  logic                enter_btn,
  output logic                waiting_led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEBOUNCE_CYC);
  // In ARM the current sample is the last one needed when cnt already holds
  // DEBOUNCE_CYC-1 earlier low samples.
  localparam logic [CNT_W-1:0] CNT_ARM_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DEB   = 3'd3,
    ST_GRANT = 3'd4
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        sync_reg;
  logic [DATA_W-1:0] in_data_reg;
  logic              in_valid_reg;
  logic              waiting_led_reg;
  logic              enter_s;
  logic [DATA_W-1:0] sw_ext;

  // Second synchronizer flop is the only view of the button the FSM uses.
  assign enter_s = sync_reg[1];

  // Zero-extend the switches to a register-file word; written bit by bit so
  // that SW_W == DATA_W needs no zero-width replication.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < SW_W) begin : g_sw
        assign sw_ext[gi] = switches[gi];
      end else begin : g_zero
        assign sw_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg        <= 2'b00;
      state_reg       <= ST_IDLE;
      cnt_reg         <= CNT_ZERO;
      in_data_reg     <= '0;
      in_valid_reg    <= 1'b0;
      waiting_led_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], enter_btn};
      in_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= CNT_ZERO;
          if (bus.halt_req) begin
            state_reg       <= ST_ARM;
            waiting_led_reg <= 1'b1;
          end else begin
            waiting_led_reg <= 1'b0;
          end
        end

        // Require a debounced release first, so a press that was already
        // held when Halt rose can never be taken as the answer.
        ST_ARM: begin
          if (!bus.halt_req) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= CNT_ZERO;
            waiting_led_reg <= 1'b0;
          end else if (enter_s) begin
            cnt_reg <= CNT_ZERO;
          end else if (cnt_reg == CNT_ARM_LAST) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= CNT_ZERO;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_WAIT: begin
          if (!bus.halt_req) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= CNT_ZERO;
            waiting_led_reg <= 1'b0;
          end else if (enter_s) begin
            // This high sample already counts toward the debounce window.
            state_reg <= ST_DEB;
            cnt_reg   <= CNT_ONE;
          end else begin
            cnt_reg <= CNT_ZERO;
          end
        end

        ST_DEB: begin
          if (!bus.halt_req) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= CNT_ZERO;
            waiting_led_reg <= 1'b0;
          end else if (!enter_s) begin
            // Bounce: go back and wait for the next rising level.
            state_reg <= ST_WAIT;
            cnt_reg   <= CNT_ZERO;
          end else if (cnt_reg == CNT_FULL) begin
            state_reg       <= ST_GRANT;
            cnt_reg         <= CNT_ZERO;
            in_data_reg     <= sw_ext;
            in_valid_reg    <= 1'b1;
            waiting_led_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        // Single release cycle; a following IN must start over from IDLE.
        ST_GRANT: begin
          state_reg       <= ST_IDLE;
          cnt_reg         <= CNT_ZERO;
          waiting_led_reg <= 1'b0;
        end

        default: begin
          state_reg       <= ST_IDLE;
          cnt_reg         <= CNT_ZERO;
          waiting_led_reg <= 1'b0;
        end
      endcase
    end
  end

  // The stall is combinational on halt_req so the CPU freezes in the very
  // cycle Halt rises; only the GRANT cycle lets the instruction complete.
  assign bus.cpu_stall = bus.halt_req & (state_reg != ST_GRANT);
  assign bus.in_valid  = in_valid_reg;
  assign bus.in_data   = in_data_reg;
  assign waiting_led   = waiting_led_reg;

endmodule

// File: tb/tb_in_halt_responder.sv
module tb_in_halt_responder;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int DEB    = 4;
  // Edges from the one that first sees the raw press to the one that raises
  // in_valid: 2 synchronizer + DEB debounce samples + 1 grant.
  localparam int LAT    = 2 + DEB + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [SW_W-1:0]   switches;
  logic              enter_btn;
  logic              waiting_led;

  in_halt_responder_if #(.DATA_W(DATA_W)) bus ();

  in_halt_responder #(
    .DATA_W      (DATA_W),
    .SW_W        (SW_W),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .switches   (switches),
    .enter_btn  (enter_btn),
    .waiting_led(waiting_led)
  );

  always #5 clock = ~clock;

  int              n_checks = 0;
  int              n_pass   = 0;
  logic [DATA_W-1:0] model_data;
  bit              prev_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock tick: apply inputs, let one rising edge pass, check on the
  // falling edge against the expectations supplied by the caller.
  task automatic step(input logic h, input logic e, input logic [SW_W-1:0] sw,
                      input logic r, input logic ev, input logic ew);
    bus.halt_req = h;
    enter_btn    = e;
    switches     = sw;
    reset        = r;
    @(posedge clock);
    @(negedge clock);
    chk("in_valid",    {31'b0, bus.in_valid},  {31'b0, ev});
    chk("cpu_stall",   {31'b0, bus.cpu_stall}, {31'b0, h & ~ev});
    chk("waiting_led", {31'b0, waiting_led},   {31'b0, ew});
    chk("in_data",     bus.in_data,            model_data);
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, e, SW_W'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // One IN instruction answered by the user. Enter waveform: 'stuck' ticks
  // held from before, 'pre_low' ticks released, up to two bounce pairs
  // (h ticks high, l ticks low; h=0 skips), then held high. The pulse is due
  // LAT-1 ticks after the tick of the final rising edge.
  task automatic do_in(input logic [SW_W-1:0] sw, input bit b2b, input int stuck,
                       input int pre_low, input int h0, input int l0,
                       input int h1, input int l1);
    bit wave[$];
    int r, p, a;
    logic e;
    for (int i = 0; i < stuck; i++) wave.push_back(1'b1);
    for (int i = 0; i < pre_low; i++) wave.push_back(1'b0);
    if (h0 > 0) begin
      for (int i = 0; i < h0; i++) wave.push_back(1'b1);
      for (int i = 0; i < l0; i++) wave.push_back(1'b0);
    end
    if (h1 > 0) begin
      for (int i = 0; i < h1; i++) wave.push_back(1'b1);
      for (int i = 0; i < l1; i++) wave.push_back(1'b0);
    end
    r = wave.size();
    p = r + LAT - 1;
    // Right after a grant the responder spends one tick idle before it notices
    // the next Halt; otherwise it notices on the first tick.
    a = b2b ? 1 : 0;
    for (int i = 0; i <= p; i++) begin
      e = (i < r) ? logic'(wave[i]) : 1'b1;
      if (i == p) model_data = {{(DATA_W-SW_W){1'b0}}, sw};
      step(1'b1, e, sw, 1'b0, logic'(i == p), logic'(i >= a && i < p));
    end
    $display("IN sw=%h b2b=%0d stuck=%0d pre_low=%0d bounce=%0d/%0d,%0d/%0d pulse_tick=%0d",
             sw, b2b, stuck, pre_low, h0, l0, h1, l1, p);
  endtask

  // Halt withdrawn (or reset asserted) while the press is being debounced.
  task automatic do_abort(input logic [SW_W-1:0] sw, input bit use_reset);
    int r, d;
    r = 6 + int'($urandom_range(0, 3));
    d = r + 3 + int'($urandom_range(0, 2));
    for (int i = 0; i < d; i++) step(1'b1, logic'(i >= r), sw, 1'b0, 1'b0, 1'b1);
    if (!use_reset) begin
      step(1'b0, 1'b1, sw, 1'b0, 1'b0, 1'b0);
    end else begin
      model_data = '0;
      step(1'b1, 1'b1, sw, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, sw, 1'b1, 1'b0, 1'b0);
    end
    $display("ABORT sw=%h via_reset=%0d press_tick=%0d drop_tick=%0d", sw, use_reset, r, d);
  endtask

  initial begin
    int kind, stuck;
    logic [SW_W-1:0] sw;
    model_data = '0;
    prev_grant = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0);
    $display("RESET held 3 ticks");
    idle(2, 1'b0);

    do_in(16'h00A5, 1'b0, 0, 6, 0, 0, 0, 0);
    idle(2, 1'b0);
    do_in(16'h5A5A, 1'b0, 0, 6, 2, 1, 0, 0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    do_in(16'h0F0F, 1'b0, 8, 6, 0, 0, 0, 0);
    idle(2, 1'b0);
    do_abort(16'hBEEF, 1'b0);
    idle(2, 1'b0);
    do_abort(16'hCAFE, 1'b1);
    idle(2, 1'b0);
    do_in(16'h0003, 1'b0, 0, 6, 0, 0, 0, 0);
    do_in(16'hFFFF, 1'b1, 0, 6, 0, 0, 0, 0);
    idle(2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      sw   = SW_W'($urandom);
      if (kind == 3) begin
        idle(int'($urandom_range(1, 3)), 1'b0);
        do_abort(sw, bit'($urandom_range(0, 1)));
        prev_grant = 1'b0;
      end else begin
        stuck = (kind == 2) ? int'($urandom_range(5, 9)) : 0;
        if (kind == 1 && prev_grant) begin
          do_in(sw, 1'b1, stuck, int'($urandom_range(6, 10)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end else begin
          idle(int'($urandom_range(1, 3)), logic'(kind == 2));
          do_in(sw, 1'b0, stuck, int'($urandom_range(6, 10)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end
        prev_grant = 1'b1;
      end
    end
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
